mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately, independent of clk.
REQ-004 a_i  input  8  unsigned multiplicand; sampled only on accepted start.
REQ-005 b_i  input  8  unsigned multiplier; sampled only on accepted start.
REQ-006 start  input  1  request pulse; accepted only when idle.
REQ-007 result  output  16  registered unsigned product a_i*b_i of last completed operation.
REQ-008 busy  output  1  registered; 1 while an operation is in progress.
REQ-009 sum_in_a  output  16  first operand driven to the external combinational adder.
REQ-010 sum_in_b  output  16  second operand driven to the external combinational adder.
REQ-011 sum_out  input  16  external adder result; the adder SHALL supply (sum_in_a+sum_in_b) mod 2^16 in the same cycle.

Function
REQ-012 The block SHALL implement unsigned shift-and-add multiplication with exactly one external-adder addition per work cycle and no internal "+" on the datapath, except the 3-bit iteration counter.
REQ-013 States SHALL be IDLE and WORK.
REQ-014 IDLE: busy=0. On a rising edge with start=1: latch a_i zero-extended to 16 bits into multiplicand register M, latch b_i into multiplier register Q, clear accumulator ACC to 0, clear counter to 0, go to WORK.
REQ-015 WORK: busy=1. Every cycle, drive sum_in_a=ACC and sum_in_b=(Q[0] ? M : 0).
REQ-016 Each WORK edge: ACC<=sum_out, M<=M<<1 (16-bit), Q<=Q>>1, counter<=counter+1.
REQ-017 On the WORK edge with counter=7: load result<=sum_out, return to IDLE; busy falls at that edge.
REQ-018 Latency: busy SHALL be 1 for exactly 8 cycles, starting at the edge that accepts start; result is valid at the edge at which busy falls.
REQ-019 In IDLE, sum_in_a and sum_in_b SHALL be 0.
REQ-020 start asserted while busy=1 SHALL be ignored; a_i/b_i changes during WORK SHALL have no effect.
REQ-021 start held high continuously SHALL start a new operation on the first edge after returning to IDLE.
REQ-022 result SHALL hold its value from completion until the next completion; it SHALL NOT change during WORK.
REQ-023 Zero operands SHALL still take the full 8 cycles; product 0.
REQ-024 The maximum product 255*255=65025 SHALL fit in 16 bits with no overflow.

Reset
REQ-025 While rst=0: state=IDLE, busy=0, result=0, ACC=M=0, Q=0, counter=0, sum_in_a=sum_in_b=0.
REQ-026 Reset asserted mid-operation SHALL abort it immediately; result SHALL be 0, not a partial product.
REQ-027 After rst returns to 1, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-028 Reset, then a_i=3, b_i=2, start pulse -> busy high 8 cycles, then busy=0 and result=6.
REQ-029 a_i=5, b_i=5 -> result=25; a_i=4, b_i=3 -> result=12.
REQ-030 a_i=255, b_i=255 -> result=65025 (0xFE01).
REQ-031 a_i=255, b_i=0 -> result=0 after 8 busy cycles.
REQ-032 Start 7*9, pulse start again with 2*2 at busy cycle 3 -> second start ignored, result=63.
REQ-033 Start 200*100, assert rst=0 at busy cycle 4 -> busy=0 and result=0 immediately; after release, 6*7 -> result=42.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// Each work cycle performs one addition through an external combinational adder.
module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic        start,
    output logic [15:0] result,
    output logic        busy,
    output logic [15:0] sum_in_a,
    output logic [15:0] sum_in_b,
    input  logic [15:0] sum_out
);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] m_q, m_d;
    logic [7:0]  q_q, q_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        m_d      = m_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        sum_in_a = '0;
        sum_in_b = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {8'd0, a_i};
                    q_d     = b_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = WORK;
                end
            end
            WORK: begin
                // Add the shifted multiplicand only when the current multiplier bit is set.
                sum_in_a = acc_q;
                sum_in_b = q_q[0] ? m_q : 16'd0;
                acc_d    = sum_out;
                m_d      = {m_q[14:0], 1'b0};
                q_d      = {1'b0, q_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    res_d   = sum_out;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == WORK);
    assign result = res_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq.
// The bench supplies the external adder and checks products and timing.
module tb_mul_seq;

    logic        clk;
    logic        rst;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        start;
    logic [15:0] result;
    logic        busy;
    logic [15:0] sum_in_a;
    logic [15:0] sum_in_b;
    logic [15:0] sum_out;

    int n_chk;
    int n_fail;

    mul_seq dut (
        .clk      (clk),
        .rst      (rst),
        .a_i      (a_i),
        .b_i      (b_i),
        .start    (start),
        .result   (result),
        .busy     (busy),
        .sum_in_a (sum_in_a),
        .sum_in_b (sum_in_b),
        .sum_out  (sum_out)
    );

    assign sum_out = sum_in_a + sum_in_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b,
                          input string tag);
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " busy_rise"}, busy, 1);
    endtask

    // Waits for busy to fall; cyc0 is the number of busy cycles already seen.
    task automatic wait_done(input int cyc0, input logic [15:0] exp,
                             input string tag);
        int          cyc;
        logic [15:0] prev;
        logic        held;
        bit          done;
        cyc  = cyc0;
        prev = result;
        held = 1'b1;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                done = 1;
                break;
            end
            if (result !== prev) held = 1'b0;
            cyc++;
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy_cycles"}, cyc, 8);
        check({tag, " result_held"}, held, 1);
        check({tag, " result"}, result, exp);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string tag);
        accept(a, b, tag);
        @(negedge clk);
        start = 1'b0;
        wait_done(1, exp, tag);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        start  = 1'b0;
        a_i    = '0;
        b_i    = '0;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst result", result, 0);
        check("rst sum_in_a", sum_in_a, 0);
        check("rst sum_in_b", sum_in_b, 0);
        rst = 1'b1;

        run_op(8'd3, 8'd2, 16'd6, "3x2");
        run_op(8'd5, 8'd5, 16'd25, "5x5");
        run_op(8'd4, 8'd3, 16'd12, "4x3");
        run_op(8'd255, 8'd255, 16'hFE01, "255x255");
        run_op(8'd255, 8'd0, 16'd0, "255x0");
        run_op(8'd0, 8'd0, 16'd0, "0x0");
        @(negedge clk);
        check("idle sum_in_a", sum_in_a, 0);
        check("idle sum_in_b", sum_in_b, 0);

        // Second start during work must be ignored.
        accept(8'd7, 8'd9, "7x9");
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a_i   = 8'd2;
        b_i   = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, 16'd63, "7x9 ign");

        // Start held high: operand changes during work are ignored,
        // and a new operation begins right after completion.
        accept(8'd10, 8'd11, "hold1");
        @(negedge clk);
        a_i = 8'd12;
        b_i = 8'd2;
        wait_done(1, 16'd110, "hold1");
        @(posedge clk);
        #1;
        check("hold restart busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 16'd24, "hold2");

        // Reset mid-operation aborts immediately.
        accept(8'd200, 8'd100, "abort");
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort result", result, 0);
        check("abort sum_in_a", sum_in_a, 0);
        check("abort sum_in_b", sum_in_b, 0);
        @(negedge clk);
        rst = 1'b1;
        run_op(8'd6, 8'd7, 16'd42, "6x7");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
